// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, feeder state encoding and sample type for the
// FIR front end.
package fir_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_FRAME_LEN = 20;  // 80 taps / 4 per cycle

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_sample_feeder_fifo.sv
// sample_fifo: synchronous FIFO with registered full/empty flags and a level
// output. Reads are taken from the registered head, so a word written on an
// edge becomes visible no earlier than the following cycle.
module sample_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned  AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;
    logic [AW:0]       level_nxt;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy: +1 on write, -1 on read, unchanged when both or neither.
    always_comb begin
        level_nxt = level;
        if (do_wr && !do_rd) begin
            level_nxt = level + LVL_ONE;
        end else if (!do_wr && do_rd) begin
            level_nxt = level - LVL_ONE;
        end
    end

    // Storage array; contents need no reset since the flags guard reads.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_nxt;
            full  <= (level_nxt == FULL_LVL);
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers incoming samples and presents one sample per
// FRAME_LEN-cycle filter frame on fir_sig/fir_ready, aligned so that each new
// sample arrives on the filter's shift edge.
// Build option: define FEEDER_HOLD_LAST_EN to repeat the previous sample on
// underrun instead of inserting zero (the underrun flag is set either way).
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic signed [DATA_W-1:0]  s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic signed [DATA_W-1:0]  fir_sig,
    output logic                      fir_ready,
    output logic                      frame_end,
    output logic                      underrun,
    input  logic                      clr_underrun,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int unsigned       CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    feeder_state_t      state;
    logic [CNT_W-1:0]   cnt;
    logic               frame_last;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               underrun_set;
    logic [DATA_W-1:0]  fifo_head;

    assign s_ready      = !fifo_full;
    assign frame_last   = (state == RUN) && (cnt == CNT_LAST);
    assign underrun_set = frame_last && enable && fifo_empty;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (s_data),
        .wr_en   (s_valid),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Pop the head when starting from IDLE or on a frame-end edge while enabled.
    always_comb begin
        fifo_pop = 1'b0;
        if (enable && !fifo_empty && ((state == IDLE) || frame_last)) begin
            fifo_pop = 1'b1;
        end
    end

    // Frame sequencing: start, per-frame reload, underrun fill and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fir_sig   <= '0;
            fir_ready <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable && !fifo_empty) begin
                        state     <= RUN;
                        fir_sig   <= fifo_head;
                        fir_ready <= 1'b1;
                    end else begin
                        fir_sig   <= '0;
                        fir_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (frame_last) begin
                        cnt       <= '0;
                        frame_end <= 1'b1;
                        if (!enable) begin
                            state     <= DRAIN;
                            fir_sig   <= '0;
                            fir_ready <= 1'b0;
                        end else if (!fifo_empty) begin
                            fir_sig <= fifo_head;
                        end else begin
`ifdef FEEDER_HOLD_LAST_EN
                            fir_sig <= fir_sig;
`else
                            fir_sig <= '0;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    fir_sig   <= '0;
                    fir_ready <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    fir_sig   <= '0;
                    fir_ready <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag; a new underrun wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Upstream stage of the FIR filter. It accepts 8-bit signed samples over a valid/ready handshake from the sample source and buffers them in a small FIFO. It drives the filter's `input_sig`/`ready` pair so that each sample is held for one full FRAME_LEN-cycle accumulation window. Its frame counter mirrors the filter's tap index, so each new sample lands exactly on the filter's shift cycle.

## Interface
Parameters:
- DATA_W, 8, sample width (signed two's complement)
- DEPTH, 8, FIFO depth in samples; power of two, ≥ 2
- FRAME_LEN, 20, cycles per filter frame (80 taps / 4 per cycle)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; sampled every cycle
- s_data  in  DATA_W  signed input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  feeder can accept; equals !fifo_full
- fir_sig  out  DATA_W  sample to filter `input_sig`, registered
- fir_ready  out  1  to filter `ready`, registered
- frame_end  out  1  one-cycle pulse: filter output has just updated
- underrun  out  1  sticky flag: a zero sample was inserted
- clr_underrun  in  1  synchronous clear of underrun
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- A push occurs when s_valid && s_ready. There is no bypass: a pushed sample is poppable on the following cycle at the earliest.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Drives fir_ready=0 and fir_sig=0. The filter shifts zeros every cycle, which flushes its delay line.
  - Goes to RUN when enable && fifo_level≠0. On that edge it pops the head into fir_sig, sets cnt=0 and sets fir_ready=1.
- RUN:
  - Drives fir_ready=1. cnt increments by 1 each cycle, 0..FRAME_LEN-1.
  - At cnt=FRAME_LEN-1 the filter shifts in fir_sig on the edge. On the same edge the feeder does the following:
    - cnt wraps to 0.
    - If enable=0, it goes to DRAIN.
    - Otherwise, if the FIFO is non-empty, it pops the head into fir_sig.
    - Otherwise it loads fir_sig=0 and sets underrun=1. It stays in RUN with fir_ready held high, so the filter state is not disturbed.
- DRAIN:
  - Lasts one cycle. fir_ready=0 and fir_sig=0, then the block returns to IDLE.
- Simultaneous push at full with pop: the push is refused, because s_ready reflects the registered full flag.
- Push to an empty FIFO on the frame-end edge: it does not satisfy that pop. A zero is inserted and underrun is set.
- If clr_underrun is asserted in the same cycle as a new underrun, the set wins.
- fifo_level changes by +1 on push, −1 on pop, and 0 on simultaneous push and pop.
- No arithmetic is performed on data. Samples pass through bit-exact. The inserted zero is 0 in DATA_W.

## Timing
- Reset (async assert, synchronous deassert at the board level) drives:
  - state=IDLE, cnt=0, FIFO empty
  - fir_sig=0, fir_ready=0, frame_end=0, underrun=0
  - s_ready=1, fifo_level=0
- Start latency: a sample pushed in cycle t with the block in IDLE and enable=1 appears on fir_sig with fir_ready=1 in cycle t+2.
- frame_end is high in the cycle after the edge where cnt=FRAME_LEN-1. This is the first cycle in which the filter's `filtred_sig` reflects the just-shifted sample.
- Steady throughput is one sample per FRAME_LEN cycles.
- Reset asserted mid-frame aborts immediately, the FIFO contents are discarded, and the filter sees fir_ready=0.

## Configuration
- FEEDER_HOLD_LAST_EN:
  - Defined: on underrun, fir_sig keeps the previous sample instead of loading 0. The underrun flag is still set.
  - Undefined: zero insertion, as specified above.

## Structure
- Package fir_pkg holds:
  - DATA_W and FRAME_LEN defaults
  - the feeder state enum (IDLE, RUN, DRAIN)
  - a typedef for signed sample_t
- One sub-module, sample_fifo: synchronous FIFO with registered full/empty flags and a level output, no read bypass.
- The frame counter, state machine and underrun logic live in fir_sample_feeder.

## Test plan
- Reset then idle: no input, enable=1 for 50 cycles. Required: fir_ready=0, fir_sig=0, frame_end never pulses, s_ready=1.
- Single sample: push 0x40 at cycle 10. Required:
  - fir_sig=0x40 and fir_ready=1 from cycle 12.
  - Underrun zero is loaded at the cycle-31 edge, with frame_end at cycle 32 and underrun=1.
- Back-to-back stream: push 0x01..0x08 as fast as s_ready allows. Required:
  - Each value is held for exactly 20 cycles, in order.
  - s_ready drops when fifo_level=8.
  - No underrun until the FIFO empties.
- Full-with-pop collision: fill to 8, hold s_valid at a frame-end edge. Required: push refused that cycle, fifo_level goes 8→7, accepted next cycle.
- Disable mid-frame: deassert enable at cnt=5. Required:
  - The frame completes through cnt=19.
  - One DRAIN cycle with fir_ready=0, then IDLE.
  - Remaining FIFO contents are retained.
- Async reset at cnt=10 with fifo_level=3. Required: all outputs at reset values immediately, fifo_level=0. With FEEDER_HOLD_LAST_EN defined, the underrun case repeats the last sample instead of 0.
